// File: rtl/pc_unit.sv
// pc_unit: program-counter unit at the head of fetch.
//
// Holds the architectural PC and selects the next PC from four sources:
// sequential, conditional branch, register-indirect and return address.
// It supports a stall hold. It can optionally include a circular
// return-address stack (RAS) for call/return prediction.
//
// Optional feature macro: PC_RAS_EN
//   defined   -> RAS storage is built; link pushes and RETURN pops.
//   undefined -> no RAS; RETURN targets reg1+off; link is ignored;
//                rasCount=0, rasEmpty=1, rasFull=0.
//
// Parameters:
//   DBITS     PC / operand width
//   START_PC  PC value loaded on reset
//   IMM_SHIFT left shift applied to imm (word offsets)
//   RAS_DEPTH RAS entries (>= 2)
//
// Ports:
//   clk        clock; all state updates on posedge
//   reset      asynchronous, active-low reset
//   stall      hold PC and RAS this cycle
//   pcSel      0=PCPLUSFOUR 1=PCOFFSET 2=REGOFFSET 3=RETURN
//   cmp        branch condition for PCOFFSET
//   imm        signed offset, pre-shift
//   reg1       register base for REGOFFSET and the RETURN fallback
//   link       push return address (call)
//   pcOut      current PC
//   pcPlusFour pcOut + 4 (combinational)
//   rasCount   number of valid RAS entries
//   rasEmpty   rasCount == 0
//   rasFull    rasCount == RAS_DEPTH
module pc_unit #(
    parameter int          DBITS     = 32,
    parameter int unsigned START_PC  = 64,
    parameter int          IMM_SHIFT = 2,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic [1:0]                       pcSel,
    input  logic                             cmp,
    input  logic [DBITS-1:0]                 imm,
    input  logic [DBITS-1:0]                 reg1,
    input  logic                             link,
    output logic [DBITS-1:0]                 pcOut,
    output logic [DBITS-1:0]                 pcPlusFour,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   rasCount,
    output logic                             rasEmpty,
    output logic                             rasFull
);

    localparam int CW = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {
        SEL_PCPLUSFOUR = 2'd0,
        SEL_PCOFFSET   = 2'd1,
        SEL_REGOFFSET  = 2'd2,
        SEL_RETURN     = 2'd3
    } pcSel_t;

    logic [DBITS-1:0] pc;
    logic [DBITS-1:0] nextPc;
    logic [DBITS-1:0] off;
    logic [DBITS-1:0] branchPc;
    logic [DBITS-1:0] regPc;
    logic [DBITS-1:0] rasTop;
    logic             rasValid;
    logic             transferTaken;

    // The shift truncates to DBITS, and all adds wrap modulo 2^DBITS.
    assign off        = imm << IMM_SHIFT;
    assign pcPlusFour = pc + DBITS'(4);
    assign branchPc   = pcPlusFour + off;
    assign regPc      = reg1 + off;
    assign pcOut      = pc;

    // Next-PC select. transferTaken marks the transfers that may push a
    // return address. RETURN counts as taken so that a co-routine call can
    // push and pop in the same cycle.
    always_comb begin
        nextPc        = pcPlusFour;
        transferTaken = 1'b0;
        case (pcSel_t'(pcSel))
            SEL_PCPLUSFOUR: begin
                nextPc = pcPlusFour;
            end
            SEL_PCOFFSET: begin
                if (cmp) begin
                    nextPc        = branchPc;
                    transferTaken = 1'b1;
                end
            end
            SEL_REGOFFSET: begin
                nextPc        = regPc;
                transferTaken = 1'b1;
            end
            SEL_RETURN: begin
                nextPc        = rasValid ? rasTop : regPc;
                transferTaken = 1'b1;
            end
            default: begin
                nextPc = pcPlusFour;
            end
        endcase
    end

    // PC register. Reset is asynchronous; stall freezes the PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= DBITS'(START_PC);
        end else if (!stall) begin
            pc <= nextPc;
        end
    end

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [DBITS-1:0] rasMem [RAS_DEPTH];
    logic [PW-1:0]    topPtr;
    logic [PW-1:0]    topPtrNext;
    logic [PW-1:0]    incPtr;
    logic [PW-1:0]    decPtr;
    logic [PW-1:0]    writePtr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    countNext;
    logic             doPush;
    logic             doPop;
    logic             writeEn;

    assign rasEmpty = (count == '0);
    assign rasFull  = (count == CW'(RAS_DEPTH));
    assign rasCount = count;
    assign rasValid = !rasEmpty;
    assign rasTop   = rasMem[topPtr];

    assign doPush = link & transferTaken;
    assign doPop  = (pcSel == SEL_RETURN) & !rasEmpty;

    // Wrap explicitly so that non-power-of-two depths stay in range.
    assign incPtr = (topPtr == PW'(RAS_DEPTH - 1)) ? '0 : topPtr + 1'b1;
    assign decPtr = (topPtr == '0) ? PW'(RAS_DEPTH - 1) : topPtr - 1'b1;

    // RAS update. Push and pop together overwrite the top entry in place.
    // A push onto a full stack advances the pointer over the oldest entry,
    // so the count saturates at RAS_DEPTH.
    always_comb begin
        topPtrNext = topPtr;
        countNext  = count;
        writePtr   = incPtr;
        writeEn    = 1'b0;
        if (doPush && doPop) begin
            writePtr = topPtr;
            writeEn  = 1'b1;
        end else if (doPush) begin
            writePtr   = incPtr;
            writeEn    = 1'b1;
            topPtrNext = incPtr;
            if (!rasFull) begin
                countNext = count + 1'b1;
            end
        end else if (doPop) begin
            topPtrNext = decPtr;
            countNext  = count - 1'b1;
        end
    end

    // RAS pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            topPtr <= '0;
            count  <= '0;
        end else if (!stall) begin
            topPtr <= topPtrNext;
            count  <= countNext;
        end
    end

    // RAS entry storage. Entry contents need no reset because the count
    // marks which entries are valid.
    always_ff @(posedge clk) begin
        if (reset && !stall && writeEn) begin
            rasMem[writePtr] <= pcPlusFour;
        end
    end
`else
    logic [1:0] unusedBits;

    assign rasCount   = '0;
    assign rasEmpty   = 1'b1;
    assign rasFull    = 1'b0;
    assign rasValid   = 1'b0;
    assign rasTop     = '0;
    assign unusedBits = {link, transferTaken};
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit with default
// parameters (START_PC=0x40, RAS_DEPTH=4). When PC_RAS_EN is undefined,
// the expected values switch to the no-RAS behaviour.
module tb_pc_unit;

    localparam logic [1:0] SEL_SEQ = 2'd0;
    localparam logic [1:0] SEL_OFF = 2'd1;
    localparam logic [1:0] SEL_REG = 2'd2;
    localparam logic [1:0] SEL_RET = 2'd3;

`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pcSel = 2'd0;
    logic        cmp = 1'b0;
    logic [31:0] imm = 32'h0;
    logic [31:0] reg1 = 32'h0;
    logic        link = 1'b0;
    logic [31:0] pcOut;
    logic [31:0] pcPlusFour;
    logic [2:0]  rasCount;
    logic        rasEmpty;
    logic        rasFull;

    int checkCount = 0;
    int passCount  = 0;

    pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .pcSel      (pcSel),
        .cmp        (cmp),
        .imm        (imm),
        .reg1       (reg1),
        .link       (link),
        .pcOut      (pcOut),
        .pcPlusFour (pcPlusFour),
        .rasCount   (rasCount),
        .rasEmpty   (rasEmpty),
        .rasFull    (rasFull)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the posedge.
    task automatic applyStimulus(input logic [1:0] sel, input logic c,
                                 input logic [31:0] i, input logic [31:0] r,
                                 input logic l);
        pcSel = sel;
        cmp   = c;
        imm   = i;
        reg1  = r;
        link  = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetPc", pcOut, 32'h40);
        checkOutput("resetPcPlusFour", pcPlusFour, 32'h44);
        checkOutput("resetCount", 32'(rasCount), 32'd0);
        checkOutput("resetEmpty", 32'(rasEmpty), 32'd1);
        checkOutput("resetFull", 32'(rasFull), 32'd0);

        // Release reset and increment three times
        reset = 1'b1;
        repeat (3) applyStimulus(SEL_SEQ, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("incrementPc", pcOut, 32'h4C);
        checkOutput("incrementPlusFour", pcPlusFour, 32'h50);

        // Branches: not taken, then taken
        applyStimulus(SEL_OFF, 1'b0, 32'h4, 32'h0, 1'b0);
        checkOutput("branchNotTaken", pcOut, 32'h50);
        applyStimulus(SEL_OFF, 1'b1, 32'h4, 32'h0, 1'b0);
        checkOutput("branchTaken", pcOut, 32'h64);

        // Call and return
        applyStimulus(SEL_REG, 1'b0, 32'h4, 32'h50, 1'b1);
        checkOutput("callPc", pcOut, 32'h60);
        checkOutput("callCount", 32'(rasCount), RAS_ON ? 32'd1 : 32'd0);
        applyStimulus(SEL_RET, 1'b0, 32'h0, 32'h300, 1'b0);
        checkOutput("returnPc", pcOut, RAS_ON ? 32'h68 : 32'h300);
        checkOutput("returnCount", 32'(rasCount), 32'd0);
        checkOutput("returnEmpty", 32'(rasEmpty), 32'd1);

        // Overflow: jump to 0x1000, then five calls
        applyStimulus(SEL_REG, 1'b0, 32'h0, 32'h1000, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(SEL_REG, 1'b0, 32'h0, 32'h1000 + 32'(k) * 32'h100, 1'b1);
        end
        checkOutput("fourCallsCount", 32'(rasCount), RAS_ON ? 32'd4 : 32'd0);
        checkOutput("fourCallsFull", 32'(rasFull), RAS_ON ? 32'd1 : 32'd0);
        applyStimulus(SEL_REG, 1'b0, 32'h0, 32'h1500, 1'b1);
        checkOutput("overflowPc", pcOut, 32'h1500);
        checkOutput("overflowCount", 32'(rasCount), RAS_ON ? 32'd4 : 32'd0);
        checkOutput("overflowFull", 32'(rasFull), RAS_ON ? 32'd1 : 32'd0);

        // Four returns in LIFO order; the oldest address 0x1004 was lost
        for (int k = 0; k < 4; k++) begin
            applyStimulus(SEL_RET, 1'b0, 32'h0, 32'h900, 1'b0);
            checkOutput("lifoPc", pcOut, RAS_ON ? (32'h1404 - 32'(k) * 32'h100) : 32'h900);
            checkOutput("lifoCount", 32'(rasCount), RAS_ON ? 32'(3 - k) : 32'd0);
        end

        // Underflow falls back to reg1+off
        applyStimulus(SEL_RET, 1'b0, 32'h0, 32'h100, 1'b0);
        checkOutput("underflowPc", pcOut, 32'h100);
        checkOutput("underflowCount", 32'(rasCount), 32'd0);

        // Stall with two entries while RETURN is requested
        applyStimulus(SEL_REG, 1'b0, 32'h0, 32'h2000, 1'b1);
        applyStimulus(SEL_REG, 1'b0, 32'h0, 32'h3000, 1'b1);
        checkOutput("preStallCount", 32'(rasCount), RAS_ON ? 32'd2 : 32'd0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(SEL_RET, 1'b0, 32'h0, 32'h700, 1'b0);
            checkOutput("stallPc", pcOut, 32'h3000);
            checkOutput("stallCount", 32'(rasCount), RAS_ON ? 32'd2 : 32'd0);
        end
        stall = 1'b0;
        applyStimulus(SEL_RET, 1'b0, 32'h0, 32'h700, 1'b0);
        checkOutput("postStallPc", pcOut, RAS_ON ? 32'h2004 : 32'h700);
        checkOutput("postStallCount", 32'(rasCount), RAS_ON ? 32'd1 : 32'd0);

        // Co-routine call: the top entry (0x104) is replaced by 0x2008
        applyStimulus(SEL_REG, 1'b0, 32'h0, 32'h2004, 1'b0);
        applyStimulus(SEL_RET, 1'b0, 32'h0, 32'h700, 1'b1);
        checkOutput("coroutinePc", pcOut, RAS_ON ? 32'h104 : 32'h700);
        checkOutput("coroutineCount", 32'(rasCount), RAS_ON ? 32'd1 : 32'd0);
        applyStimulus(SEL_RET, 1'b0, 32'h0, 32'h700, 1'b0);
        checkOutput("coroutineReturnPc", pcOut, RAS_ON ? 32'h2008 : 32'h700);
        checkOutput("coroutineReturnCount", 32'(rasCount), 32'd0);

        // RETURN with link on an empty stack: fallback target plus a push
        applyStimulus(SEL_RET, 1'b0, 32'h1, 32'h800, 1'b1);
        checkOutput("emptyRetLinkPc", pcOut, 32'h804);
        checkOutput("emptyRetLinkCount", 32'(rasCount), RAS_ON ? 32'd1 : 32'd0);
        applyStimulus(SEL_RET, 1'b0, 32'h0, 32'h900, 1'b0);
        checkOutput("emptyRetLinkPopPc", pcOut, RAS_ON ? 32'h200C : 32'h900);

        // Link on a not-taken branch is ignored; negative offset branch
        applyStimulus(SEL_OFF, 1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("linkIgnoredPc", pcOut, RAS_ON ? 32'h2010 : 32'h904);
        checkOutput("linkIgnoredCount", 32'(rasCount), 32'd0);
        applyStimulus(SEL_OFF, 1'b1, 32'hFFFF_FFFE, 32'h0, 1'b0);
        checkOutput("negBranchPc", pcOut, RAS_ON ? 32'h200C : 32'h900);

        // Asynchronous reset between edges with three entries
        for (int k = 4; k <= 6; k++) begin
            applyStimulus(SEL_REG, 1'b0, 32'h0, 32'(k) * 32'h1000, 1'b1);
        end
        checkOutput("preResetCount", 32'(rasCount), RAS_ON ? 32'd3 : 32'd0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("asyncResetPc", pcOut, 32'h40);
        checkOutput("asyncResetPlusFour", pcPlusFour, 32'h44);
        checkOutput("asyncResetCount", 32'(rasCount), 32'd0);
        checkOutput("asyncResetEmpty", 32'(rasEmpty), 32'd1);
        checkOutput("asyncResetFull", 32'(rasFull), 32'd0);
        #1;
        reset = 1'b1;

        // RETURN on an empty stack (or with no RAS) uses reg1+off
        applyStimulus(SEL_RET, 1'b0, 32'h1, 32'h80, 1'b0);
        checkOutput("fallbackReturnPc", pcOut, 32'h84);
        checkOutput("fallbackReturnCount", 32'(rasCount), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised next-generation program-counter unit for the single-issue core. It holds the architectural PC and selects the next PC from sequential, conditional-branch, register-indirect and return-address sources. It adds a stall hold and a configurable-depth return-address stack (RAS) for call/return prediction. The unit sits at the head of fetch and drives the instruction-memory address every cycle.

## Interface
- DBITS, 32, PC and operand width
- START_PC, 64, PC value loaded on reset
- IMM_SHIFT, 2, left shift applied to imm before adding (word offsets)
- RAS_DEPTH, 4, RAS entries; must be ≥ 2
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and RAS this cycle
- pcSel  in  2  0 = PCPLUSFOUR, 1 = PCOFFSET, 2 = REGOFFSET, 3 = RETURN
- cmp  in  1  branch condition for PCOFFSET
- imm  in  DBITS  signed offset, pre-shift
- reg1  in  DBITS  register base for REGOFFSET and RETURN fallback
- link  in  1  push return address (call)
- pcOut  out  DBITS  current PC
- pcPlusFour  out  DBITS  pcOut + 4, combinational
- rasCount  out  $clog2(RAS_DEPTH+1)  valid RAS entries
- rasEmpty  out  1  rasCount == 0
- rasFull  out  1  rasCount == RAS_DEPTH

## Operation
- off = imm << IMM_SHIFT, truncated to DBITS. All adds are modulo 2^DBITS. No alignment forcing.
- Next-PC selection:
  - PCPLUSFOUR: pc+4.
  - PCOFFSET: pc+4+off if cmp, else pc+4.
  - REGOFFSET: reg1+off.
  - RETURN: RAS top if !rasEmpty, else reg1+off.
- Push value is pc+4 of the current PC.
- Push occurs when link=1 and the selected transfer is taken:
  - REGOFFSET, always taken;
  - PCOFFSET with cmp=1;
  - RETURN.
- link with PCPLUSFOUR, or with PCOFFSET and cmp=0, is ignored.
- Pop occurs on RETURN with !rasEmpty.
- RETURN and push together (co-routine call): the top entry is replaced by the push value. rasCount is unchanged, or becomes 1 if the RAS was empty.
- Push when full: the oldest entry is overwritten (circular buffer) and rasCount stays at RAS_DEPTH.
- Pop when empty: no RAS change. The fallback target is used.
- stall=1: pcOut, RAS contents and rasCount hold, regardless of the other inputs.

## Timing
- pcOut, the RAS and rasCount are registered and update on posedge clk using the inputs sampled at that edge.
- pcPlusFour, rasEmpty and rasFull are combinational from the registers.
- Redirect latency is one cycle: the target appears on pcOut after the edge at which pcSel was sampled.
- Reset (reset=0) takes effect immediately, independent of clk. It may be asserted mid-operation, including between edges.
- Values under reset: pcOut=START_PC, pcPlusFour=START_PC+4, rasCount=0, rasEmpty=1, rasFull=0. RAS entry contents are don't-care.
- First update occurs on the first posedge with reset=1 that follows deassertion.

## Configuration
- Macro: PC_RAS_EN.
- Defined: RAS behaves as described above.
- Undefined:
  - no RAS storage is instantiated;
  - RETURN computes reg1+off;
  - link is ignored;
  - rasCount is held at 0, rasEmpty=1 and rasFull=0.

## Test plan
All scenarios use the defaults (START_PC=0x40, RAS_DEPTH=4).
- Reset and increment: reset=0, then release with PCPLUSFOUR. After 3 posedges, pcOut=0x4C.
- Branch:
  - from pcOut=0x4C, PCOFFSET with cmp=0 → pcOut=0x50;
  - then cmp=1, imm=4 → pcOut=0x64.
- Call and return:
  - from pcOut=0x64, REGOFFSET with link=1, reg1=0x50, imm=4 → pcOut=0x60, rasCount=1;
  - then RETURN → pcOut=0x68, rasCount=0, rasEmpty=1.
- Overflow and underflow:
  - 5 consecutive REGOFFSET calls with link=1 → rasFull=1, rasCount=4;
  - 4 RETURNs yield the last 4 return addresses in LIFO order;
  - a 5th RETURN with reg1=0x100, imm=0 → pcOut=0x100, rasCount=0.
- Stall: with rasCount=2, stall=1 for 3 cycles while applying RETURN → pcOut and rasCount unchanged. After releasing stall, the pop takes effect on the next edge.
- Async reset mid-operation: with rasCount=3, assert reset between edges → pcOut=0x40 and rasCount=0 before the next posedge. Repeat with PC_RAS_EN undefined: RETURN with reg1=0x80, imm=1 → pcOut=0x84.
